// File: rtl/bus_initiator.sv
// Bus initiator: bridges a valid/ready command stream onto a req/addr_ok/data_ok
// split-transaction bus and buffers in-order responses behind a valid/ready port.
`ifndef XLEN
`define XLEN 32
`endif

module bus_initiator #(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [`XLEN/8-1:0]   cmd_wstrb,
    input  logic [`XLEN-1:0]     cmd_addr,
    input  logic [`XLEN-1:0]     cmd_wdata,
    output logic                 req,
    output logic                 write,
    output logic [`XLEN/8-1:0]   wstrb,
    output logic [`XLEN-1:0]     addr,
    output logic [`XLEN-1:0]     wdata,
    input  logic                 addr_ok,
    input  logic                 data_ok,
    input  logic [`XLEN-1:0]     rdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_write,
    output logic [`XLEN-1:0]     rsp_rdata,
    output logic                 err_unexpected
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 2) + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [PW-1:0] ZERO_PTR = {PW{1'b0}};
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return ZERO_PTR;
        end else begin
            return p + {{(PW-1){1'b0}}, 1'b1};
        end
    endfunction

    state_e                 state_q, state_d;
    logic                   write_q, write_d;
    logic [`XLEN/8-1:0]     wstrb_q, wstrb_d;
    logic [`XLEN-1:0]       addr_q, addr_d;
    logic [`XLEN-1:0]       wdata_q, wdata_d;

    logic [CW-1:0]          out_q, out_d;
    logic [CW-1:0]          rsp_cnt_q, rsp_cnt_d;
    logic [PW-1:0]          tq_wr_q, tq_wr_d;
    logic [PW-1:0]          tq_rd_q, tq_rd_d;
    logic [PW-1:0]          rf_wr_q, rf_wr_d;
    logic [PW-1:0]          rf_rd_q, rf_rd_d;
    logic                   err_q, err_d;

    logic                   tq_mem_q   [DEPTH];
    logic                   rf_type_q  [DEPTH];
    logic [`XLEN-1:0]       rf_data_q  [DEPTH];

    logic [CW-1:0]          occ_s;
    logic                   credit_s;
    logic                   cmd_fire_s;
    logic                   addr_fire_s;
    logic                   dok_fire_s;
    logic                   dok_bad_s;
    logic                   rsp_pop_s;

    assign req       = (state_q == ST_REQ);
    assign write     = write_q;
    assign wstrb     = wstrb_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign rsp_valid = (rsp_cnt_q != ZERO_C);
    assign rsp_write = rf_type_q[rf_rd_q];
    assign rsp_rdata = rf_data_q[rf_rd_q];
    assign err_unexpected = err_q;

    // Credit counts only registered occupancy; same-cycle completions free nothing.
    assign occ_s       = CW'(req) + out_q + rsp_cnt_q;
    assign credit_s    = (occ_s < DEPTH_C);
    assign cmd_ready   = rst_b & credit_s & ((state_q == ST_IDLE) | (req & addr_ok));
    assign cmd_fire_s  = cmd_valid & cmd_ready;
    assign addr_fire_s = req & addr_ok;
    assign dok_fire_s  = data_ok & (out_q != ZERO_C);
    assign dok_bad_s   = data_ok & (out_q == ZERO_C);
    assign rsp_pop_s   = rsp_valid & rsp_ready;

    // Request FSM next state and bus field capture.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (addr_ok) begin
                    if (cmd_fire_s) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (cmd_fire_s) begin
            write_d = cmd_write;
            wstrb_d = cmd_wstrb;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
        end else begin
            write_d = write_q;
            wstrb_d = wstrb_q;
            addr_d  = addr_q;
            wdata_d = wdata_q;
        end
    end

    // Outstanding/response counters, queue pointers and the sticky error.
    always_comb begin
        out_d     = out_q;
        rsp_cnt_d = rsp_cnt_q;
        tq_wr_d   = tq_wr_q;
        tq_rd_d   = tq_rd_q;
        rf_wr_d   = rf_wr_q;
        rf_rd_d   = rf_rd_q;
        err_d     = err_q | dok_bad_s;
        case ({addr_fire_s, dok_fire_s})
            2'b10:   out_d = out_q + ONE_C;
            2'b01:   out_d = out_q - ONE_C;
            default: out_d = out_q;
        endcase
        case ({dok_fire_s, rsp_pop_s})
            2'b10:   rsp_cnt_d = rsp_cnt_q + ONE_C;
            2'b01:   rsp_cnt_d = rsp_cnt_q - ONE_C;
            default: rsp_cnt_d = rsp_cnt_q;
        endcase
        if (addr_fire_s) begin
            tq_wr_d = ptr_inc(tq_wr_q);
        end else begin
            tq_wr_d = tq_wr_q;
        end
        if (dok_fire_s) begin
            tq_rd_d = ptr_inc(tq_rd_q);
            rf_wr_d = ptr_inc(rf_wr_q);
        end else begin
            tq_rd_d = tq_rd_q;
            rf_wr_d = rf_wr_q;
        end
        if (rsp_pop_s) begin
            rf_rd_d = ptr_inc(rf_rd_q);
        end else begin
            rf_rd_d = rf_rd_q;
        end
    end

    // FSM state and bus request field registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            wstrb_q <= {(`XLEN/8){1'b0}};
            addr_q  <= {`XLEN{1'b0}};
            wdata_q <= {`XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Counter, pointer and error registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_q     <= ZERO_C;
            rsp_cnt_q <= ZERO_C;
            tq_wr_q   <= ZERO_PTR;
            tq_rd_q   <= ZERO_PTR;
            rf_wr_q   <= ZERO_PTR;
            rf_rd_q   <= ZERO_PTR;
            err_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            rsp_cnt_q <= rsp_cnt_d;
            tq_wr_q   <= tq_wr_d;
            tq_rd_q   <= tq_rd_d;
            rf_wr_q   <= rf_wr_d;
            rf_rd_q   <= rf_rd_d;
            err_q     <= err_d;
        end
    end

    // Type queue and response FIFO storage; the popped type travels with its rdata.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                tq_mem_q[i]  <= 1'b0;
                rf_type_q[i] <= 1'b0;
                rf_data_q[i] <= {`XLEN{1'b0}};
            end
        end else begin
            if (addr_fire_s) begin
                tq_mem_q[tq_wr_q] <= write_q;
            end
            if (dok_fire_s) begin
                rf_type_q[rf_wr_q] <= tq_mem_q[tq_rd_q];
                rf_data_q[rf_wr_q] <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: a per-cycle vector table for the DEPTH=2
// instance plus hand sequences for same-cycle events, spurious data_ok and reset.
`ifndef XLEN
`define XLEN 32
`endif

module tb_bus_initiator;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cmd_valid, cmd_write;
    logic [3:0]  cmd_wstrb;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        addr_ok, data_ok, rsp_ready;
    logic [31:0] rdata;

    logic        cmd_ready, req, write, rsp_valid, rsp_write, err_unexpected;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata, rsp_rdata;

    logic        d3_cmd_ready, d3_req, d3_write, d3_rsp_valid, d3_rsp_write, d3_err;
    logic [3:0]  d3_wstrb;
    logic [31:0] d3_addr, d3_wdata, d3_rsp_rdata;

    int checks;
    int errors;

    always #5 clk = ~clk;

    bus_initiator #(.DEPTH(2)) u_dut (
        .clk(clk), .rst_b(rst_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_wstrb(cmd_wstrb), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .req(req), .write(write), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .err_unexpected(err_unexpected)
    );

    // Deeper instance so that request, outstanding and buffered entries can coexist.
    bus_initiator #(.DEPTH(3)) u_dut3 (
        .clk(clk), .rst_b(rst_b),
        .cmd_valid(cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_write(cmd_write),
        .cmd_wstrb(cmd_wstrb), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .req(d3_req), .write(d3_write), .wstrb(d3_wstrb), .addr(d3_addr), .wdata(d3_wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(d3_rsp_write),
        .rsp_rdata(d3_rsp_rdata), .err_unexpected(d3_err)
    );

    typedef struct {
        logic        cv;
        logic        cw;
        logic [31:0] ca;
        logic [31:0] cd;
        logic [3:0]  cs;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        rr;
        logic        e_crdy;
        logic        e_req;
        logic        e_w;
        logic [31:0] e_a;
        logic [31:0] e_d;
        logic [3:0]  e_s;
        logic        e_rv;
        logic        e_rw;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic cv, input logic cw, input logic [31:0] ca,
                                input logic [31:0] cd, input logic [3:0] cs,
                                input logic aok, input logic dok, input logic [31:0] rd,
                                input logic rr, input logic e_crdy, input logic e_req,
                                input logic e_w, input logic [31:0] e_a, input logic [31:0] e_d,
                                input logic [3:0] e_s, input logic e_rv, input logic e_rw,
                                input logic [31:0] e_rd);
        vec_t v;
        v.cv = cv; v.cw = cw; v.ca = ca; v.cd = cd; v.cs = cs;
        v.aok = aok; v.dok = dok; v.rd = rd; v.rr = rr;
        v.e_crdy = e_crdy; v.e_req = e_req; v.e_w = e_w; v.e_a = e_a; v.e_d = e_d;
        v.e_s = e_s; v.e_rv = e_rv; v.e_rw = e_rw; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setin(input logic cv, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic [3:0] cs, input logic aok,
                         input logic dok, input logic [31:0] rd, input logic rr);
        cmd_valid = cv; cmd_write = cw; cmd_addr = ca; cmd_wdata = cd; cmd_wstrb = cs;
        addr_ok = aok; data_ok = dok; rdata = rd; rsp_ready = rr;
    endtask

    task automatic idle_in();
        setin(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_b  = 1'b1;
        idle_in();
        #2 rst_b = 1'b0;
        @(negedge clk);
        chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst req",       {31'd0, req}, 32'd0);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst err",       {31'd0, err_unexpected}, 32'd0);
        chk("rst write",     {31'd0, write}, 32'd0);
        chk("rst wstrb",     {28'd0, wstrb}, 32'd0);
        chk("rst addr",      addr, 32'd0);
        chk("rst wdata",     wdata, 32'd0);

        // Single read: addr_ok at once, data_ok two cycles later.
        vecs.push_back(mk(1'b1,1'b0,32'h10,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0,1'b0, 1'b1,1'b1,1'b0,32'h10,32'h0,4'h0, 1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'hDEADBEEF,1'b0, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b1, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'hDEADBEEF));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0));
        // Back-to-back with credit exhaustion; a pop does not free credit in its own cycle.
        vecs.push_back(mk(1'b1,1'b0,32'h100,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h104,32'h0,4'h0, 1'b1,1'b0,32'h0,1'b0, 1'b1,1'b1,1'b0,32'h100,32'h0,4'h0, 1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h108,32'h0,4'h0, 1'b1,1'b0,32'h0,1'b0, 1'b0,1'b1,1'b0,32'h104,32'h0,4'h0, 1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h108,32'h0,4'h0, 1'b0,1'b1,32'h11111111,1'b0, 1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h108,32'h0,4'h0, 1'b0,1'b1,32'h22222222,1'b0, 1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h11111111));
        vecs.push_back(mk(1'b1,1'b0,32'h108,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0, 1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h11111111));
        vecs.push_back(mk(1'b1,1'b0,32'h108,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b1, 1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h11111111));
        vecs.push_back(mk(1'b1,1'b0,32'h108,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h22222222));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h0,1'b0, 1'b0,1'b1,1'b0,32'h108,32'h0,4'h0, 1'b1,1'b0,32'h22222222));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h33333333,1'b1, 1'b0,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h22222222));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b1, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h33333333));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0));
        // addr_ok stall on a write while the command inputs change underneath.
        vecs.push_back(mk(1'b1,1'b1,32'h20000000,32'h55,4'h1, 1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0));
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(1'b0,1'b0,32'hFFFFFFFF,32'hA5A5A5A5,4'hE, 1'b0,1'b0,32'h0,1'b0, 1'b0,1'b1,1'b1,32'h20000000,32'h55,4'h1, 1'b0,1'b0,32'h0));
        end
        vecs.push_back(mk(1'b0,1'b0,32'hFFFFFFFF,32'hA5A5A5A5,4'hE, 1'b1,1'b0,32'h0,1'b0, 1'b1,1'b1,1'b1,32'h20000000,32'h55,4'h1, 1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'hCAFEF00D,1'b0, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b1, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b1,32'hCAFEF00D));
        vecs.push_back(mk(1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0));

        do_reset();
        foreach (vecs[i]) begin
            setin(vecs[i].cv, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].cs,
                  vecs[i].aok, vecs[i].dok, vecs[i].rd, vecs[i].rr);
            @(negedge clk);
            chk($sformatf("v%0d cmd_ready", i), {31'd0, cmd_ready}, {31'd0, vecs[i].e_crdy});
            chk($sformatf("v%0d req", i), {31'd0, req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].e_rv});
            chk($sformatf("v%0d err", i), {31'd0, err_unexpected}, 32'd0);
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d write", i), {31'd0, write}, {31'd0, vecs[i].e_w});
                chk($sformatf("v%0d addr", i), addr, vecs[i].e_a);
                chk($sformatf("v%0d wdata", i), wdata, vecs[i].e_d);
                chk($sformatf("v%0d wstrb", i), {28'd0, wstrb}, {28'd0, vecs[i].e_s});
            end
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d rsp_write", i), {31'd0, rsp_write}, {31'd0, vecs[i].e_rw});
                chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].e_rd);
            end
            nxt();
        end

        // Same-cycle addr_ok acceptance, data_ok and pop on the DEPTH=3 instance.
        do_reset();
        setin(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
        setin(1'b1, 1'b0, 32'h304, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        nxt();
        setin(1'b1, 1'b0, 32'h308, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        nxt();
        setin(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0);
        nxt();
        setin(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hBBBB0002, 1'b1);
        @(negedge clk);
        chk("same req", {31'd0, d3_req}, 32'd1);
        chk("same addr", d3_addr, 32'h308);
        chk("same cmd_ready full", {31'd0, d3_cmd_ready}, 32'd0);
        chk("same rsp_valid", {31'd0, d3_rsp_valid}, 32'd1);
        chk("same rsp_rdata A", d3_rsp_rdata, 32'hAAAA0001);
        nxt();
        setin(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCCCC0003, 1'b0);
        @(negedge clk);
        chk("same after req", {31'd0, d3_req}, 32'd0);
        chk("same after cmd_ready", {31'd0, d3_cmd_ready}, 32'd1);
        chk("same after rsp_rdata B", d3_rsp_rdata, 32'hBBBB0002);
        nxt();
        setin(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("same B head", d3_rsp_rdata, 32'hBBBB0002);
        chk("same no err", {31'd0, d3_err}, 32'd0);
        nxt();
        @(negedge clk);
        chk("same C valid", {31'd0, d3_rsp_valid}, 32'd1);
        chk("same C head", d3_rsp_rdata, 32'hCCCC0003);
        nxt();
        idle_in();
        @(negedge clk);
        chk("same drained", {31'd0, d3_rsp_valid}, 32'd0);
        chk("same drained err", {31'd0, d3_err}, 32'd0);

        // Spurious data_ok with nothing outstanding.
        do_reset();
        setin(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h00001234, 1'b1);
        @(negedge clk);
        chk("spur err before edge", {31'd0, err_unexpected}, 32'd0);
        nxt();
        idle_in();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("spur err c%0d", k), {31'd0, err_unexpected}, 32'd1);
            chk($sformatf("spur rsp_valid c%0d", k), {31'd0, rsp_valid}, 32'd0);
            chk($sformatf("spur cmd_ready c%0d", k), {31'd0, cmd_ready}, 32'd1);
            nxt();
        end
        @(negedge clk);
        #1 rst_b = 1'b0;
        #1 chk("spur err cleared by reset", {31'd0, err_unexpected}, 32'd0);

        // Reset with one outstanding write and one buffered read response.
        do_reset();
        setin(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        nxt();
        setin(1'b1, 1'b1, 32'h404, 32'h99, 4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        nxt();
        setin(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h77777777, 1'b0);
        @(negedge clk);
        chk("mid req write", {31'd0, write}, 32'd1);
        chk("mid addr", addr, 32'h404);
        nxt();
        idle_in();
        @(negedge clk);
        chk("mid rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mid rsp_rdata", rsp_rdata, 32'h77777777);
        chk("mid cmd_ready full", {31'd0, cmd_ready}, 32'd0);
        #1 rst_b = 1'b0;
        #1;
        chk("arst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("arst req", {31'd0, req}, 32'd0);
        chk("arst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst err", {31'd0, err_unexpected}, 32'd0);
        chk("arst write", {31'd0, write}, 32'd0);
        chk("arst wstrb", {28'd0, wstrb}, 32'd0);
        chk("arst addr", addr, 32'd0);
        chk("arst wdata", wdata, 32'd0);
        nxt();
        rst_b = 1'b1;
        @(negedge clk);
        chk("post rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
        nxt();
        setin(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h88888888, 1'b0);
        nxt();
        idle_in();
        @(negedge clk);
        chk("late data_ok err", {31'd0, err_unexpected}, 32'd1);
        chk("late data_ok rsp_valid", {31'd0, rsp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
